// File: rtl/bsg_mem_1rw_sync_ctrl_pkg.sv
// Shared types and constants for the 1rw sync RAM initiator.
// FSM states, response-buffer depth and address-width helper.
package bsg_mem_1rw_sync_ctrl_pkg;

   typedef enum logic {
      e_init  = 1'b0,
      e_ready = 1'b1
   } state_e;

   localparam int resp_els_lp = 2;

   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_resp_buf.sv
// Two-entry response FIFO with a bypass path from data_i.
// Captures the RAM's one-cycle read data when the consumer stalls.
module bsg_mem_1rw_sync_resp_buf
   import bsg_mem_1rw_sync_ctrl_pkg::*;
#(
   parameter int width_p = 32
)(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               enq_v_i,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i,
   output logic [1:0]         count_o
);

   logic [width_p-1:0] mem_r [resp_els_lp];
   logic               wr_ptr_r;
   logic               rd_ptr_r;
   logic [1:0]         count_r;
   logic               empty;
   logic               enq;
   logic               deq;

   assign empty   = (count_r == 2'd0);
   assign deq     = yumi_i & ~empty;
   assign enq     = enq_v_i & ~(empty & yumi_i);
   assign v_o     = ~empty | enq_v_i;
   assign data_o  = empty ? data_i : mem_r[rd_ptr_r];
   assign count_o = count_r;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (enq) wr_ptr_r <= ~wr_ptr_r;
         if (deq) rd_ptr_r <= ~rd_ptr_r;
         unique case ({enq, deq})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wr_ptr_r] <= data_i;
   end

   a_count: assert property (@(posedge clk_i) disable iff (reset_i)
      count_r <= 2'(resp_els_lp));

endmodule

// File: rtl/bsg_mem_1rw_sync_ctrl.sv
// Initiator for a single-port synchronous RAM.
// Optional zero-fill after reset, then valid/ready requests and buffered reads.
module bsg_mem_1rw_sync_ctrl
   import bsg_mem_1rw_sync_ctrl_pkg::*;
#(
   parameter int width_p       = 32,
   parameter int els_p         = 64,
   parameter int init_p        = 1,
   parameter int addr_width_lp = safe_clog2(els_p)
)(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     v_i,
   input  logic                     w_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [width_p-1:0]       data_i,
   output logic                     ready_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   input  logic                     yumi_i,
   output logic                     init_done_o,
   output logic                     mem_v_o,
   output logic                     mem_w_o,
   output logic [addr_width_lp-1:0] mem_addr_o,
   output logic [width_p-1:0]       mem_data_o,
   input  logic [width_p-1:0]       mem_data_i
);

   localparam logic [addr_width_lp-1:0] last_addr_lp =
      addr_width_lp'(els_p - 1);

   state_e                   state_r;
   state_e                   state_n;
   logic [addr_width_lp-1:0] init_cnt_r;
   logic                     rd_inflight_r;
   logic [1:0]               count;
   logic [2:0]               credits;
   logic                     ready;
   logic                     accept;

   // Outstanding reads = one in the RAM pipe plus whatever is buffered.
   assign credits = {1'b0, count} + {2'b00, rd_inflight_r};
   assign ready   = (state_r == e_ready) & ~reset_i
                  & (credits < 3'(resp_els_lp));
   assign accept  = v_i & ready;

   // State register; skips zero-fill when init is disabled.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_r <= (init_p != 0) ? e_init : e_ready;
      else         state_r <= state_n;
   end

   // Leave INIT once the last word has been written.
   always_comb begin
      state_n = state_r;
      unique case (state_r)
         e_init:  if (init_cnt_r == last_addr_lp) state_n = e_ready;
         e_ready: state_n = e_ready;
      endcase
   end

   // RAM port mux and handshake outputs.
   always_comb begin
      ready_o     = ready;
      init_done_o = 1'b0;
      mem_v_o     = 1'b0;
      mem_w_o     = 1'b0;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      unique case (state_r)
         e_init: begin
            mem_v_o    = ~reset_i;
            mem_w_o    = 1'b1;
            mem_addr_o = init_cnt_r;
         end
         e_ready: begin
            init_done_o = ~reset_i;
            if (accept) begin
               mem_v_o    = 1'b1;
               mem_w_o    = w_i;
               mem_addr_o = addr_i;
               mem_data_o = data_i;
            end
         end
      endcase
   end

   // Zero-fill address walks the array once.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                 init_cnt_r <= '0;
      else if (state_r == e_init)  init_cnt_r <= init_cnt_r + 1'b1;
   end

   // Read data shows up on mem_data_i one cycle after an accepted read.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) rd_inflight_r <= 1'b0;
      else         rd_inflight_r <= accept & ~w_i;
   end

   bsg_mem_1rw_sync_resp_buf #(
      .width_p (width_p)
   ) resp_buf (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .enq_v_i (rd_inflight_r),
      .data_i  (mem_data_i),
      .v_o     (v_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i),
      .count_o (count)
   );

   a_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
      !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_mem_1rw_sync_ctrl.sv
// Bench for bsg_mem_1rw_sync_ctrl: one init_p=1 and one init_p=0 instance,
// each paired with a non-latching 1rw sync RAM and a queue scoreboard.
module tb_bsg_mem_1rw_sync_ctrl;

   localparam int W  = 32;
   localparam int N  = 64;
   localparam int AW = 6;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          v     [2];
   logic          w     [2];
   logic          rdy   [2];
   logic          vo    [2];
   logic          yumi  [2];
   logic          done  [2];
   logic          mv    [2];
   logic          mw    [2];
   logic [AW-1:0] addr  [2];
   logic [AW-1:0] maddr [2];
   logic [W-1:0]  din   [2];
   logic [W-1:0]  dout  [2];
   logic [W-1:0]  mdout [2];
   logic [W-1:0]  mdin  [2];

   int total = 0;
   int bad   = 0;

   logic [W-1:0] mdl [N];
   logic [W-1:0] q [$];

   always #5 clk = ~clk;

   bsg_mem_1rw_sync_ctrl #(.width_p(W), .els_p(N), .init_p(0)) dut0 (
      .clk_i(clk), .reset_i(reset),
      .v_i(v[0]), .w_i(w[0]), .addr_i(addr[0]), .data_i(din[0]),
      .ready_o(rdy[0]), .v_o(vo[0]), .data_o(dout[0]), .yumi_i(yumi[0]),
      .init_done_o(done[0]),
      .mem_v_o(mv[0]), .mem_w_o(mw[0]), .mem_addr_o(maddr[0]),
      .mem_data_o(mdout[0]), .mem_data_i(mdin[0])
   );

   bsg_mem_1rw_sync_ctrl #(.width_p(W), .els_p(N), .init_p(1)) dut1 (
      .clk_i(clk), .reset_i(reset),
      .v_i(v[1]), .w_i(w[1]), .addr_i(addr[1]), .data_i(din[1]),
      .ready_o(rdy[1]), .v_o(vo[1]), .data_o(dout[1]), .yumi_i(yumi[1]),
      .init_done_o(done[1]),
      .mem_v_o(mv[1]), .mem_w_o(mw[1]), .mem_addr_o(maddr[1]),
      .mem_data_o(mdout[1]), .mem_data_i(mdin[1])
   );

   for (genvar g = 0; g < 2; g++) begin : g_ram
      logic [W-1:0] ram [N];
      logic [W-1:0] rd;
      // Non-latching RAM: read data is junk except the cycle after a read.
      always @(posedge clk) begin
         rd <= $urandom;
         if (mv[g]) begin
            if (mw[g]) ram[maddr[g]] <= mdout[g];
            else       rd <= ram[maddr[g]];
         end
      end
      assign mdin[g] = rd;
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic zero_inputs();
      for (int k = 0; k < 2; k++) begin
         v[k] = 1'b0; w[k] = 1'b0; yumi[k] = 1'b0;
         addr[k] = '0; din[k] = '0;
      end
   endtask

   // One post-init cycle on instance k, checked against the queue model.
   task automatic cyc(input int k, input logic vv, input logic ww,
                      input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic y);
      logic yy;
      logic er;
      logic acc;
      @(negedge clk);
      yy = y & (q.size() > 0);
      v[k] = vv; w[k] = ww; addr[k] = a; din[k] = d; yumi[k] = yy;
      #1;
      er  = (q.size() < 2);
      acc = vv & er;
      check("done",  64'(done[k]), 64'(1));
      check("ready", 64'(rdy[k]),  64'(er));
      check("v_o",   64'(vo[k]),   64'(q.size() > 0));
      check("mem_v", 64'(mv[k]),   64'(acc));
      if (acc) begin
         check("mem_w",    64'(mw[k]),    64'(ww));
         check("mem_addr", 64'(maddr[k]), 64'(a));
         if (ww) check("mem_data", 64'(mdout[k]), 64'(d));
      end
      if (yy) begin
         check("data", 64'(dout[k]), 64'(q[0]));
         void'(q.pop_front());
      end
      if (acc) begin
         if (ww) mdl[a] = d;
         else    q.push_back(mdl[a]);
      end
   endtask

   task automatic idle(input int k, input logic y, input int n);
      repeat (n) cyc(k, 1'b0, 1'b0, '0, '0, y);
   endtask

   task automatic rand_mix(input int k, input int n);
      repeat (n)
         cyc(k, ($urandom % 4) != 0, 1'($urandom), AW'($urandom),
             $urandom, ($urandom % 4) != 0);
   endtask

   // Asynchronous reset pulse; every instance must go quiet at once.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      zero_inputs();
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_v_o",  64'(vo[k]),   64'(0));
         check("rst_rdy",  64'(rdy[k]),  64'(0));
         check("rst_done", 64'(done[k]), 64'(0));
         check("rst_mem_v", 64'(mv[k]),  64'(0));
      end
      q.delete();
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++)
         check("rst_mem_v_hold", 64'(mv[k]), 64'(0));
      reset = 1'b0;
      #1;
   endtask

   // Zero-fill walk with junk requests offered; they must be ignored.
   task automatic wait_init(input int k);
      int n = 0;
      v[k] = 1'b1;
      w[k] = 1'b1;
      while (!done[k] && n < 200) begin
         check("init_rdy",  64'(rdy[k]),   64'(0));
         check("init_v_o",  64'(vo[k]),    64'(0));
         check("init_mem",  64'({mv[k], mw[k]}), 64'(2'b11));
         check("init_addr", 64'(maddr[k]), 64'(n % N));
         check("init_data", 64'(mdout[k]), 64'(0));
         n++;
         @(negedge clk);
         addr[k] = AW'($urandom);
         din[k]  = $urandom;
         #1;
      end
      v[k] = 1'b0;
      w[k] = 1'b0;
      check("init_cycles", 64'(n), 64'(N));
      for (int a = 0; a < N; a++) mdl[a] = '0;
   endtask

   initial begin
      zero_inputs();
      do_reset();
      wait_init(1);

      for (int a = 0; a < N; a++) cyc(1, 1'b1, 1'b0, AW'(a), '0, 1'b1);
      idle(1, 1'b1, 3);

      for (int a = 0; a < N; a++) cyc(1, 1'b1, 1'b1, AW'(a), $urandom, 1'b0);
      repeat (100) cyc(1, 1'b1, 1'b0, AW'($urandom), '0, 1'b1);
      idle(1, 1'b1, 3);

      cyc(1, 1'b1, 1'b1, 6'd3, 32'hA5A5A5A5, 1'b0);
      cyc(1, 1'b1, 1'b1, 6'd4, 32'h5A5A5A5A, 1'b0);
      cyc(1, 1'b1, 1'b0, 6'd3, '0, 1'b0);
      cyc(1, 1'b1, 1'b0, 6'd4, '0, 1'b0);
      cyc(1, 1'b1, 1'b0, 6'd5, '0, 1'b0);
      check("bp_ready", 64'(rdy[1]), 64'(0));
      cyc(1, 1'b0, 1'b0, '0, '0, 1'b1);
      check("bp_first", 64'(dout[1]), 64'(32'hA5A5A5A5));
      cyc(1, 1'b0, 1'b0, '0, '0, 1'b1);
      check("bp_second", 64'(dout[1]), 64'(32'h5A5A5A5A));
      idle(1, 1'b1, 2);

      cyc(1, 1'b1, 1'b1, 6'd7, 32'hDEADBEEF, 1'b0);
      cyc(1, 1'b1, 1'b0, 6'd7, '0, 1'b1);
      cyc(1, 1'b0, 1'b0, '0, '0, 1'b1);
      check("raw_v", 64'(vo[1]), 64'(1));
      check("raw_data", 64'(dout[1]), 64'(32'hDEADBEEF));
      idle(1, 1'b1, 2);

      rand_mix(1, 300);
      idle(1, 1'b1, 3);

      cyc(1, 1'b1, 1'b0, 6'd3, '0, 1'b0);
      cyc(1, 1'b1, 1'b0, 6'd4, '0, 1'b0);
      cyc(1, 1'b0, 1'b0, '0, '0, 1'b0);
      do_reset();
      wait_init(1);
      idle(1, 1'b1, 5);
      cyc(1, 1'b1, 1'b0, 6'd3, '0, 1'b1);
      idle(1, 1'b1, 2);

      do_reset();
      check("i0_rdy",  64'(rdy[0]),  64'(1));
      check("i0_done", 64'(done[0]), 64'(1));
      check("i0_v_o",  64'(vo[0]),   64'(0));
      for (int a = 0; a < N; a++) cyc(0, 1'b1, 1'b1, AW'(a), $urandom, 1'b0);
      rand_mix(0, 400);
      idle(0, 1'b1, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
